shot_detect: RTL and testbench

- Downstream consumer of the dual-axis flick filter. Takes the filtered X/Y flick magnitudes on the 4 MHz domain and recognises one basketball "shot" gesture at a time.
- Detection sequence: qualified start, active window, end or timeout, then cooldown.
- Per shot it reports one registered result: peak X, peak Y, duration in samples, and a timeout flag.
- The result feeds the shot-physics/scoring logic and the 7-seg freeze path in place of raw live flick values.

---
 rtl/shot_detect.sv | 167 ++++++++++++++++
 tb/tb_shot_detect.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_detect.sv
// shot_detect: recognises one flick "shot" gesture at a time from the
// filtered X/Y flick magnitudes. The flow is qualified start (ARM), active
// window (ACTIVE), end by quiet run or timeout, then a cooldown period. Each
// shot publishes a registered result with a one-cycle shot_valid pulse.
module shot_detect #(
  parameter logic [15:0] START_TH  = 16'd400,
  parameter logic [15:0] END_TH    = 16'd150,
  parameter int unsigned START_CNT = 3,
  parameter int unsigned END_CNT   = 4,
  parameter int unsigned MAX_LEN   = 200,
  parameter int unsigned COOLDOWN  = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [15:0] x_flick,
  input  logic [15:0] y_flick,
  output logic        shot_valid,
  output logic [15:0] shot_peak_x,
  output logic [15:0] shot_peak_y,
  output logic [7:0]  shot_len,
  output logic        shot_timeout,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ARM      = 2'd1;
  localparam logic [1:0] S_ACTIVE   = 2'd2;
  localparam logic [1:0] S_COOLDOWN = 2'd3;

  localparam logic [3:0] START_CNT_W = START_CNT[3:0];
  localparam logic [3:0] END_CNT_W   = END_CNT[3:0];
  localparam logic [7:0] MAX_LEN_W   = MAX_LEN[7:0];
  localparam logic [7:0] COOLDOWN_W  = COOLDOWN[7:0];

  logic [1:0]  r_state;
  logic        r_busy;
  logic [3:0]  r_run;
  logic [3:0]  r_qcnt;
  logic [7:0]  r_len;
  logic [7:0]  r_cd;
  logic [15:0] r_peak_x;
  logic [15:0] r_peak_y;
  logic        r_shot_valid;
  logic [15:0] r_shot_peak_x;
  logic [15:0] r_shot_peak_y;
  logic [7:0]  r_shot_len;
  logic        r_shot_timeout;

  logic        w_start;
  logic        w_quiet;
  logic [15:0] w_px_max;
  logic [15:0] w_py_max;
  logic [3:0]  w_run_inc;
  logic [7:0]  w_len_inc;
  logic [3:0]  w_q_next;
  logic [7:0]  w_cd_inc;
  logic        w_end_quiet;
  logic        w_end_max;

  // Sample classification, running maxima and incremented counter values.
  always_comb begin
    w_start     = (y_flick >= START_TH);
    w_quiet     = (y_flick < END_TH);
    w_px_max    = (x_flick > r_peak_x) ? x_flick : r_peak_x;
    w_py_max    = (y_flick > r_peak_y) ? y_flick : r_peak_y;
    w_run_inc   = r_run + 4'd1;
    w_len_inc   = r_len + 8'd1;
    w_q_next    = w_quiet ? (r_qcnt + 4'd1) : 4'd0;
    w_cd_inc    = r_cd + 8'd1;
    w_end_quiet = (w_q_next == END_CNT_W);
    w_end_max   = (w_len_inc == MAX_LEN_W);
  end

  // Gesture FSM, working counters/peaks and the published result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_run          <= '0;
      r_qcnt         <= '0;
      r_len          <= '0;
      r_cd           <= '0;
      r_peak_x       <= '0;
      r_peak_y       <= '0;
      r_shot_valid   <= 1'b0;
      r_shot_peak_x  <= '0;
      r_shot_peak_y  <= '0;
      r_shot_len     <= '0;
      r_shot_timeout <= 1'b0;
    end else begin
      r_shot_valid <= 1'b0;
      if (sample_valid) begin
        case (r_state)
          S_IDLE: begin
            if (w_start) begin
              r_peak_x <= x_flick;
              r_peak_y <= y_flick;
              r_len    <= 8'd1;
              r_run    <= 4'd1;
              r_qcnt   <= '0;
              r_busy   <= 1'b1;
              r_state  <= (START_CNT_W == 4'd1) ? S_ACTIVE : S_ARM;
            end
          end
          S_ARM: begin
            if (w_start) begin
              r_run    <= w_run_inc;
              r_len    <= w_len_inc;
              r_peak_x <= w_px_max;
              r_peak_y <= w_py_max;
              r_qcnt   <= '0;
              if (w_run_inc == START_CNT_W) r_state <= S_ACTIVE;
            end else begin
              r_run    <= '0;
              r_len    <= '0;
              r_peak_x <= '0;
              r_peak_y <= '0;
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
          S_ACTIVE: begin
            r_len    <= w_len_inc;
            r_peak_x <= w_px_max;
            r_peak_y <= w_py_max;
            r_qcnt   <= w_q_next;
            // Quiet end takes priority over the length limit on the same sample.
            if (w_end_quiet || w_end_max) begin
              r_shot_valid   <= 1'b1;
              r_shot_peak_x  <= w_px_max;
              r_shot_peak_y  <= w_py_max;
              r_shot_len     <= w_len_inc;
              r_shot_timeout <= ~w_end_quiet;
              r_cd           <= '0;
              r_state        <= S_COOLDOWN;
            end
          end
          default: begin
            if (w_cd_inc == COOLDOWN_W) begin
              r_cd     <= '0;
              r_run    <= '0;
              r_qcnt   <= '0;
              r_len    <= '0;
              r_peak_x <= '0;
              r_peak_y <= '0;
              r_busy   <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_cd <= w_cd_inc;
            end
          end
        endcase
      end
    end
  end

  assign shot_valid   = r_shot_valid;
  assign shot_peak_x  = r_shot_peak_x;
  assign shot_peak_y  = r_shot_peak_y;
  assign shot_len     = r_shot_len;
  assign shot_timeout = r_shot_timeout;
  assign busy         = r_busy;
  assign state_dbg    = r_state;

endmodule

// File: tb/tb_shot_detect.sv
// Testbench for shot_detect: scenario tasks drive flick samples, push the
// expected shot records to a queue and compare them against the shots
// captured from the DUT (including the cycle in which they appeared).
module tb_shot_detect;

  typedef struct packed {
    logic [15:0] px;
    logic [15:0] py;
    logic [7:0]  len;
    logic        to;
    logic [31:0] cyc;
  } shot_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [15:0] x_flick = '0;
  logic [15:0] y_flick = '0;
  logic        shot_valid;
  logic [15:0] shot_peak_x;
  logic [15:0] shot_peak_y;
  logic [7:0]  shot_len;
  logic        shot_timeout;
  logic        busy;
  logic [1:0]  state_dbg;

  int unsigned cyc = 0;
  int unsigned last_cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  shot_t exp_q[$];
  shot_t obs_q[$];
  shot_t o, e;

  shot_detect #(
    .START_TH (16'd400),
    .END_TH   (16'd150),
    .START_CNT(3),
    .END_CNT  (4),
    .MAX_LEN  (200),
    .COOLDOWN (50)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .x_flick     (x_flick),
    .y_flick     (y_flick),
    .shot_valid  (shot_valid),
    .shot_peak_x (shot_peak_x),
    .shot_peak_y (shot_peak_y),
    .shot_len    (shot_len),
    .shot_timeout(shot_timeout),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance to the next falling edge and capture any shot pulse.
  task automatic tick();
    @(negedge clk);
    if (shot_valid === 1'b1)
      obs_q.push_back({shot_peak_x, shot_peak_y, shot_len, shot_timeout, cyc});
  endtask

  // One strobed sample followed by one idle cycle.
  task automatic send(input logic [15:0] x, input logic [15:0] y);
    sample_valid = 1'b1;
    x_flick = x;
    y_flick = y;
    tick();
    last_cyc = cyc;
    sample_valid = 1'b0;
    tick();
  endtask

  task automatic push_exp(input logic [15:0] px, input logic [15:0] py,
                          input logic [7:0] len, input logic to);
    exp_q.push_back({px, py, len, to, last_cyc});
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({shot_valid, shot_peak_x, shot_peak_y, shot_len, shot_timeout, busy, state_dbg} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b px=%0d py=%0d len=%0d to=%b busy=%b st=%0d required all 0",
               shot_valid, shot_peak_x, shot_peak_y, shot_len, shot_timeout, busy, state_dbg);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 20; i++) send(16'd50, 16'd100);
    n_cmp++;
    if ({state_dbg, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL idle_noise_state: got st=%0d busy=%b required st=0 busy=0", state_dbg, busy);
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL idle_noise_shot: got %0d shots required 0", obs_q.size());
    end
    n_cmp++;
    if ({shot_peak_x, shot_peak_y, shot_len, shot_timeout} !== '0) begin
      n_err++;
      $display("FAIL idle_noise_outputs: got px=%0d py=%0d len=%0d to=%b required 0",
               shot_peak_x, shot_peak_y, shot_len, shot_timeout);
    end
    obs_q.delete();
  endtask

  task automatic test_basic_shot();
    logic [15:0] ys [8];
    logic [15:0] xs [8];
    ys = '{16'd500, 16'd600, 16'd900, 16'd700, 16'd100, 16'd100, 16'd100, 16'd100};
    xs = '{16'd10, 16'd40, 16'd30, 16'd20, 16'd0, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 8; i++) begin
      send(xs[i], ys[i]);
      if (i == 1) begin
        n_cmp++;
        if (state_dbg !== 2'd1) begin
          n_err++;
          $display("FAIL basic_arm_state: got %0d required 1", state_dbg);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if (state_dbg !== 2'd2) begin
          n_err++;
          $display("FAIL basic_active_state: got %0d required 2", state_dbg);
        end
      end
    end
    push_exp(16'd40, 16'd900, 8'd8, 1'b0);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_err++;
      $display("FAIL basic_shot_count: got %0d required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        n_err++;
        $display("FAIL basic_shot: got px=%0d py=%0d len=%0d to=%b cyc=%0d required px=%0d py=%0d len=%0d to=%b cyc=%0d",
                 o.px, o.py, o.len, o.to, o.cyc, e.px, e.py, e.len, e.to, e.cyc);
      end
    end
    n_cmp++;
    if ({busy, state_dbg} !== 3'b111) begin
      n_err++;
      $display("FAIL basic_cooldown_state: got busy=%b st=%0d required busy=1 st=3", busy, state_dbg);
    end
    for (int i = 0; i < 50; i++) send(16'd0, 16'd0);
    n_cmp++;
    if ({busy, state_dbg} !== 3'b000) begin
      n_err++;
      $display("FAIL basic_cooldown_exit: got busy=%b st=%0d required busy=0 st=0", busy, state_dbg);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_glitch();
    send(16'd1, 16'd500);
    send(16'd1, 16'd500);
    n_cmp++;
    if (state_dbg !== 2'd1) begin
      n_err++;
      $display("FAIL glitch_arm: got %0d required 1", state_dbg);
    end
    send(16'd1, 16'd100);
    n_cmp++;
    if ({busy, state_dbg} !== 3'b000 || obs_q.size() != 0) begin
      n_err++;
      $display("FAIL glitch_reject: got busy=%b st=%0d shots=%0d required 0/0/0", busy, state_dbg, obs_q.size());
    end
    for (int i = 0; i < 3; i++) send(16'd5, 16'd500);
    for (int i = 0; i < 4; i++) send(16'd0, 16'd100);
    push_exp(16'd5, 16'd500, 8'd7, 1'b0);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_err++;
      $display("FAIL glitch_shot_count: got %0d required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        n_err++;
        $display("FAIL glitch_shot: got px=%0d py=%0d len=%0d to=%b cyc=%0d required px=%0d py=%0d len=%0d to=%b cyc=%0d",
                 o.px, o.py, o.len, o.to, o.cyc, e.px, e.py, e.len, e.to, e.cyc);
      end
    end
    for (int i = 0; i < 50; i++) send(16'd0, 16'd0);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 200; i++) send(16'd7, 16'd500);
    push_exp(16'd7, 16'd500, 8'd200, 1'b1);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_err++;
      $display("FAIL timeout_shot_count: got %0d required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        n_err++;
        $display("FAIL timeout_shot: got px=%0d py=%0d len=%0d to=%b cyc=%0d required px=%0d py=%0d len=%0d to=%b cyc=%0d",
                 o.px, o.py, o.len, o.to, o.cyc, e.px, e.py, e.len, e.to, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_cooldown_ignore();
    for (int i = 0; i < 49; i++) send(16'd9, 16'd900);
    n_cmp++;
    if ({busy, state_dbg} !== 3'b111) begin
      n_err++;
      $display("FAIL cooldown_hold: got busy=%b st=%0d required busy=1 st=3", busy, state_dbg);
    end
    send(16'd9, 16'd100);
    n_cmp++;
    if ({busy, state_dbg} !== 3'b000) begin
      n_err++;
      $display("FAIL cooldown_exit: got busy=%b st=%0d required busy=0 st=0", busy, state_dbg);
    end
    send(16'd9, 16'd900);
    n_cmp++;
    if (state_dbg !== 2'd1) begin
      n_err++;
      $display("FAIL cooldown_rearm: got %0d required 1", state_dbg);
    end
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_err++;
      $display("FAIL cooldown_no_shot: got %0d shots required 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    send(16'd3, 16'd100);
    for (int i = 0; i < 5; i++) send(16'd3, 16'd500);
    n_cmp++;
    if (state_dbg !== 2'd2 || shot_peak_y !== 16'd500) begin
      n_err++;
      $display("FAIL areset_pre: got st=%0d py=%0d required st=2 py=500", state_dbg, shot_peak_y);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({shot_valid, shot_peak_x, shot_peak_y, shot_len, shot_timeout, busy, state_dbg} !== '0) begin
      n_err++;
      $display("FAIL areset_outputs: got v=%b px=%0d py=%0d len=%0d to=%b busy=%b st=%0d required all 0",
               shot_valid, shot_peak_x, shot_peak_y, shot_len, shot_timeout, busy, state_dbg);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    send(16'd11, 16'd500);
    send(16'd22, 16'd500);
    send(16'd33, 16'd500);
    for (int i = 0; i < 4; i++) send(16'd0, 16'd100);
    push_exp(16'd33, 16'd500, 8'd7, 1'b0);
    n_cmp++;
    if (obs_q.size() != 1) begin
      n_err++;
      $display("FAIL areset_shot_count: got %0d required 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        n_err++;
        $display("FAIL areset_shot: got px=%0d py=%0d len=%0d to=%b cyc=%0d required px=%0d py=%0d len=%0d to=%b cyc=%0d",
                 o.px, o.py, o.len, o.to, o.cyc, e.px, e.py, e.len, e.to, e.cyc);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_idle_noise();
    test_basic_shot();
    test_glitch();
    test_timeout();
    test_cooldown_ignore();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
